// File: rtl/ram_512_if.sv
// Access bus for the 512 x 16 scratch RAM.
// The client drives address, data and strobes; the RAM returns registered read data.
interface ram_512_if;
  logic        e;
  logic [15:0] DIn;
  logic [8:0]  addr;
  logic        w;
  logic        r;
  logic [15:0] DOut;

  modport master (
    output e, DIn, addr, w, r,
    input  DOut
  );

  modport slave (
    input  e, DIn, addr, w, r,
    output DOut
  );
endinterface : ram_512_if

// File: rtl/ram_512.sv
// Single-port 512 x 16 synchronous RAM with a registered output; reset clears only DOut.
// Define RAM512_WRITE_THROUGH_EN for write-first data on simultaneous read/write (default read-first).
module ram_512 (
  input logic      clk,
  ram_512_if.slave bus,
  input logic      rst
);

  logic [15:0] mem [0:511];
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_data;

  assign wr_en = bus.e & bus.w;
  assign rd_en = bus.e & bus.r;

`ifdef RAM512_WRITE_THROUGH_EN
  assign rd_data = bus.w ? bus.DIn : mem[bus.addr];
`else
  assign rd_data = mem[bus.addr];
`endif

  // NOTE: the array has no reset so it can map onto RAM macros; rst only gates the write port.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[bus.addr] <= bus.DIn;
    end
  end

  // NOTE: non-blocking assignments let the output register see the pre-write word on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.DOut <= 16'h0000;
    end else if (rd_en) begin
      bus.DOut <= rd_data;
    end
  end

endmodule : ram_512

// File: tb/tb_ram_512.sv
// Directed scoreboard bench for ram_512: fill/readback, enable gating, boundaries,
// simultaneous read/write, asynchronous reset and read hold.
module tb_ram_512;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [15:0] model [0:511];
  logic [15:0] sb [$];
  logic [15:0] exp_dout;

  ram_512_if bus ();

  ram_512 dut (
    .clk (clk),
    .bus (bus),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock of activity; expectations are pushed before the edge and checked after it.
  task automatic op(input string tag, input bit en, input bit wr, input bit rd,
                    input logic [8:0] a, input logic [15:0] d);
    bus.e    = en;
    bus.w    = wr;
    bus.r    = rd;
    bus.addr = a;
    bus.DIn  = d;
    if (en && rd) begin
`ifdef RAM512_WRITE_THROUGH_EN
      sb.push_back(wr ? d : model[a]);
`else
      sb.push_back(model[a]);
`endif
    end
    if (en && wr) model[a] = d;
    @(posedge clk);
    #1;
    if (en && rd) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s: scoreboard empty", tag);
      end else begin
        exp_dout = sb.pop_front();
      end
    end
    check(tag, bus.DOut, exp_dout);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_dout = 16'h0000;
    for (int i = 0; i < 512; i++) model[i] = 'x;
    rst      = 1'b1;
    bus.e    = 1'b0;
    bus.w    = 1'b0;
    bus.r    = 1'b0;
    bus.addr = '0;
    bus.DIn  = '0;

    #12;
    check("reset_state", bus.DOut, 16'h0000);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill even addresses, then read back with a decoy DIn
    for (int i = 0; i < 64; i++) op("fill_wr", 1'b1, 1'b1, 1'b0, 9'(2 * i), 16'(i));
    for (int i = 0; i < 64; i++) op("fill_rd", 1'b1, 1'b0, 1'b1, 9'(2 * i), 16'd100);

    // Enable gating
    op("gate_wr",      1'b1, 1'b1, 1'b0, 9'd5, 16'hBEEF);
    op("gate_rd_pre",  1'b1, 1'b0, 1'b1, 9'd6, 16'h0000);
    op("gate_off",     1'b0, 1'b1, 1'b1, 9'd5, 16'h1234);
    op("gate_off_rd",  1'b0, 1'b0, 1'b1, 9'd5, 16'h1234);
    op("gate_on_rd",   1'b1, 1'b0, 1'b1, 9'd5, 16'h0000);
    check("gate_value", bus.DOut, 16'hBEEF);

    // Boundaries
    op("bnd_wr0",   1'b1, 1'b1, 1'b0, 9'd0,   16'hAAAA);
    op("bnd_wr511", 1'b1, 1'b1, 1'b0, 9'd511, 16'h5555);
    op("bnd_rd0",   1'b1, 1'b0, 1'b1, 9'd0,   16'h0000);
    op("bnd_rd511", 1'b1, 1'b0, 1'b1, 9'd511, 16'h0000);
    op("bnd_rd0b",  1'b1, 1'b0, 1'b1, 9'd0,   16'h0000);

    // Simultaneous read/write
    op("rw_init", 1'b1, 1'b1, 1'b0, 9'd7, 16'h0011);
    op("rw_same", 1'b1, 1'b1, 1'b1, 9'd7, 16'h0022);
`ifdef RAM512_WRITE_THROUGH_EN
    check("rw_mode", bus.DOut, 16'h0022);
`else
    check("rw_mode", bus.DOut, 16'h0011);
`endif
    op("rw_after", 1'b1, 1'b0, 1'b1, 9'd7, 16'h0000);

    // Reset mid-operation with a pending write
    op("rst_wr9",  1'b1, 1'b1, 1'b0, 9'd9, 16'h0909);
    op("rst_rd",   1'b1, 1'b0, 1'b1, 9'd7, 16'h0000);
    bus.e    = 1'b1;
    bus.w    = 1'b1;
    bus.r    = 1'b0;
    bus.addr = 9'd9;
    bus.DIn  = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    exp_dout = 16'h0000;
    check("rst_async", bus.DOut, exp_dout);
    @(posedge clk);
    #1;
    check("rst_hold", bus.DOut, exp_dout);
    bus.w = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", bus.DOut, exp_dout);
    op("rst_rd9",  1'b1, 1'b0, 1'b1, 9'd9,   16'h0000);
    op("rst_rd0",  1'b1, 1'b0, 1'b1, 9'd0,   16'h0000);
    op("rst_rd62", 1'b1, 1'b0, 1'b1, 9'd62,  16'h0000);

    // Read hold while address wanders
    op("hold_rd", 1'b1, 1'b0, 1'b1, 9'd2, 16'h0000);
    for (int i = 0; i < 5; i++) op("hold", 1'b1, 1'b0, 1'b0, 9'(11 + 37 * i), 16'hFFFF);
    check("hold_value", bus.DOut, 16'h0001);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ram_512
